// File: rtl/player_motion_pkg.sv
// Shared types and default geometry for the player motion controller.
package player_motion_pkg;

  localparam int TILE_SHIFT       = 4;

  localparam int DEF_TILEMAP_LEN  = 100;
  localparam int DEF_X_W          = 11;
  localparam int DEF_Y_MAX        = 224;
  localparam int DEF_START_X      = 16;
  localparam int DEF_START_Y      = 16;
  localparam int DEF_WALK_STEP    = 2;
  localparam int DEF_JUMP_STEP    = 4;
  localparam int DEF_FALL_STEP    = 4;
  localparam int DEF_JUMP_FRAMES  = 12;

  typedef enum logic [2:0] {
    M_IDLE,
    M_START,
    M_WAIT_BUSY,
    M_WAIT_DONE,
    M_UPDATE
  } main_state_t;

  typedef enum logic [1:0] {
    V_GROUNDED,
    V_RISING,
    V_FALLING
  } vstate_t;

endpackage

// File: rtl/player_motion_jump_fsm.sv
// Vertical motion: grounded / rising / falling, with a bounded jump length.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// V_GROUNDED | standing on something; a jump request starts a rise
// V_RISING   | moving up JUMP_STEP per frame, jump_cnt frames remaining
// V_FALLING  | moving down FALL_STEP per frame until blocked or at floor
import player_motion_pkg::*;

module player_jump_fsm #(
  parameter int Y_MAX       = DEF_Y_MAX,
  parameter int START_Y     = DEF_START_Y,
  parameter int JUMP_STEP   = DEF_JUMP_STEP,
  parameter int FALL_STEP   = DEF_FALL_STEP,
  parameter int JUMP_FRAMES = DEF_JUMP_FRAMES
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       update,
  input  logic       jump,
  input  logic       blk_up,
  input  logic       blk_down,
  output logic [7:0] player_y
);

  localparam int CNT_W = $clog2(JUMP_FRAMES + 1);

  vstate_t          vstate;
  logic [CNT_W-1:0] jump_cnt;
  logic [7:0]       y_rise;
  logic [7:0]       y_fall;
  logic [8:0]       y_fall_raw;

  // Saturating candidate positions for one rising or falling step.
  always_comb begin
    y_rise     = (player_y < 8'(JUMP_STEP)) ? 8'd0 : player_y - 8'(JUMP_STEP);
    y_fall_raw = {1'b0, player_y} + 9'(FALL_STEP);
    y_fall     = (y_fall_raw > 9'(Y_MAX)) ? 8'(Y_MAX) : y_fall_raw[7:0];
  end

  // Advance the vertical state once per committed frame.
  always_ff @(posedge clock) begin
    if (reset) begin
      vstate   <= V_FALLING;
      player_y <= 8'(START_Y);
      jump_cnt <= '0;
    end else if (update) begin
      case (vstate)
        V_GROUNDED: begin
          if (jump && !blk_up) begin
            vstate   <= V_RISING;
            jump_cnt <= CNT_W'(JUMP_FRAMES);
          end else if (!blk_down && (player_y < 8'(Y_MAX))) begin
            vstate <= V_FALLING;
          end
        end
        V_RISING: begin
          if (blk_up) begin
            vstate <= V_FALLING;
          end else begin
            player_y <= y_rise;
            jump_cnt <= jump_cnt - CNT_W'(1);
            if (jump_cnt == CNT_W'(1)) vstate <= V_FALLING;
          end
        end
        V_FALLING: begin
          if (blk_down || (player_y == 8'(Y_MAX))) vstate <= V_GROUNDED;
          else player_y <= y_fall;
        end
        default: vstate <= V_FALLING;
      endcase
    end
  end

endmodule

// File: rtl/player_motion.sv
// Per-frame player position controller: latches buttons on frame_tick,
// runs one collision check at the current tile, then commits walk and
// vertical motion from a single sample of the collision flags.
//
// state       | meaning
// ------------+-------------------------------------------------------
// M_IDLE      | waiting for frame_tick; buttons latched on the tick
// M_START     | coll_enable is high for this single cycle
// M_WAIT_BUSY | waiting for coll_done to drop (ignore stale idle done)
// M_WAIT_DONE | waiting for coll_done to rise
// M_UPDATE    | sample blk_* flags and commit new position
import player_motion_pkg::*;

module player_motion #(
  parameter int TILEMAP_LEN = DEF_TILEMAP_LEN,
  parameter int X_W         = DEF_X_W,
  parameter int X_MAX       = TILEMAP_LEN * 16 - 16,
  parameter int Y_MAX       = DEF_Y_MAX,
  parameter int START_X     = DEF_START_X,
  parameter int START_Y     = DEF_START_Y,
  parameter int WALK_STEP   = DEF_WALK_STEP,
  parameter int JUMP_STEP   = DEF_JUMP_STEP,
  parameter int FALL_STEP   = DEF_FALL_STEP,
  parameter int JUMP_FRAMES = DEF_JUMP_FRAMES
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      frame_tick,
  input  logic                      btn_left,
  input  logic                      btn_right,
  input  logic                      btn_jump,
  input  logic                      blk_left,
  input  logic                      blk_right,
  input  logic                      blk_up,
  input  logic                      blk_down,
  input  logic                      coll_done,
  output logic                      coll_enable,
  output logic [X_W-TILE_SHIFT-1:0] tile_x,
  output logic [3:0]                tile_y,
  output logic [X_W-1:0]            player_x,
  output logic [7:0]                player_y,
  output logic                      pos_valid,
  output logic                      overrun
);

  main_state_t    state;
  logic           lat_left;
  logic           lat_right;
  logic           lat_jump;
  logic [X_W-1:0] next_x;
  logic           upd_strobe;

  assign upd_strobe = (state == M_UPDATE);
  assign tile_x     = player_x[X_W-1:TILE_SHIFT];
  assign tile_y     = player_y[7:TILE_SHIFT];

  // Horizontal candidate: opposing buttons cancel, blocked side holds, ends saturate.
  always_comb begin
    next_x = player_x;
    if (lat_left && !lat_right) begin
      if (!blk_left)
        next_x = (player_x < X_W'(WALK_STEP)) ? '0 : player_x - X_W'(WALK_STEP);
    end else if (lat_right && !lat_left) begin
      if (!blk_right)
        next_x = (player_x > X_W'(X_MAX - WALK_STEP)) ? X_W'(X_MAX)
                                                      : player_x + X_W'(WALK_STEP);
    end
  end

  // Frame sequencer with registered strobes and horizontal position.
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= M_IDLE;
      player_x    <= X_W'(START_X);
      lat_left    <= 1'b0;
      lat_right   <= 1'b0;
      lat_jump    <= 1'b0;
      coll_enable <= 1'b0;
      pos_valid   <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      coll_enable <= 1'b0;
      pos_valid   <= 1'b0;
      overrun     <= frame_tick && (state != M_IDLE);
      case (state)
        M_IDLE: begin
          if (frame_tick) begin
            lat_left    <= btn_left;
            lat_right   <= btn_right;
            lat_jump    <= btn_jump;
            coll_enable <= 1'b1;
            state       <= M_START;
          end
        end
        M_START:     state <= M_WAIT_BUSY;
        M_WAIT_BUSY: if (!coll_done) state <= M_WAIT_DONE;
        M_WAIT_DONE: if (coll_done) state <= M_UPDATE;
        M_UPDATE: begin
          player_x  <= next_x;
          pos_valid <= 1'b1;
          state     <= M_IDLE;
        end
        default: state <= M_IDLE;
      endcase
    end
  end

  player_jump_fsm #(
    .Y_MAX       (Y_MAX),
    .START_Y     (START_Y),
    .JUMP_STEP   (JUMP_STEP),
    .FALL_STEP   (FALL_STEP),
    .JUMP_FRAMES (JUMP_FRAMES)
  ) u_jump (
    .clock    (clock),
    .reset    (reset),
    .update   (upd_strobe),
    .jump     (lat_jump),
    .blk_up   (blk_up),
    .blk_down (blk_down),
    .player_y (player_y)
  );

endmodule

// File: tb/tb_player_motion.sv
// Self-checking bench for player_motion with an emulated collision detector.
module tb_player_motion;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic frame_tick = 1'b0;
  logic btn_left = 1'b0, btn_right = 1'b0, btn_jump = 1'b0;
  logic blk_left = 1'b0, blk_right = 1'b0, blk_up = 1'b0, blk_down = 1'b0;
  logic coll_done;
  logic coll_enable, pos_valid, overrun;
  logic [6:0]  tile_x;
  logic [3:0]  tile_y;
  logic [10:0] player_x;
  logic [7:0]  player_y;

  int n_pass = 0, n_total = 0;
  int en_cnt = 0, ovr_cnt = 0, pv_cnt = 0;
  int det_hold = 0, det_busy = 2;

  typedef enum {MV_GROUND, MV_RISE, MV_FALL} mv_t;
  int  m_x, m_y, m_jleft;
  mv_t m_v;

  always #5 clock = ~clock;

  player_motion dut (
    .clock(clock), .reset(reset), .frame_tick(frame_tick),
    .btn_left(btn_left), .btn_right(btn_right), .btn_jump(btn_jump),
    .blk_left(blk_left), .blk_right(blk_right), .blk_up(blk_up), .blk_down(blk_down),
    .coll_done(coll_done), .coll_enable(coll_enable),
    .tile_x(tile_x), .tile_y(tile_y), .player_x(player_x), .player_y(player_y),
    .pos_valid(pos_valid), .overrun(overrun)
  );

  // Pulse counters, sampled mid-cycle.
  always @(negedge clock) begin
    if (coll_enable) en_cnt++;
    if (overrun) ovr_cnt++;
    if (pos_valid) pv_cnt++;
  end

  // Collision detector: done idles high, stays high det_hold cycles after a
  // start pulse, then low det_busy cycles, then high again.
  initial begin
    coll_done = 1'b1;
    forever begin
      @(posedge clock); #1;
      if (coll_enable && !reset) begin
        repeat (det_hold) begin @(posedge clock); #1; end
        coll_done = 1'b0;
        repeat (det_busy) begin @(posedge clock); #1; end
        coll_done = 1'b1;
      end
    end
  end

  function automatic void model_reset();
    m_x = 16; m_y = 16; m_v = MV_FALL; m_jleft = 0;
  endfunction

  // One frame of motion from the behavioural rules.
  function automatic void model_step(input bit l, r, j, bl, br, bu, bd);
    if (l && !r && !bl) m_x = (m_x - 2 < 0) ? 0 : m_x - 2;
    else if (r && !l && !br) m_x = (m_x + 2 > 1584) ? 1584 : m_x + 2;
    if (m_v == MV_GROUND) begin
      if (j && !bu) begin m_v = MV_RISE; m_jleft = 12; end
      else if (!bd && m_y < 224) m_v = MV_FALL;
    end else if (m_v == MV_RISE) begin
      if (bu) m_v = MV_FALL;
      else begin
        m_y = (m_y < 4) ? 0 : m_y - 4;
        m_jleft = m_jleft - 1;
        if (m_jleft == 0) m_v = MV_FALL;
      end
    end else begin
      if (bd || m_y == 224) m_v = MV_GROUND;
      else m_y = (m_y + 4 > 224) ? 224 : m_y + 4;
    end
  endfunction

  // Drive one frame; optional extra tick at loop cycle extra_at; lat = cycles
  // from the cycle after the tick edge to pos_valid, or -1 on timeout.
  task automatic run_frame(input bit l, r, j, bl, br, bu, bd, input int extra_at, output int lat);
    int cyc;
    @(posedge clock); #1;
    btn_left = l; btn_right = r; btn_jump = j;
    blk_left = bl; blk_right = br; blk_up = bu; blk_down = bd;
    frame_tick = 1'b1;
    @(posedge clock); #1;
    frame_tick = 1'b0;
    btn_left = 1'($urandom); btn_right = 1'($urandom); btn_jump = 1'($urandom);
    cyc = 0;
    while (!pos_valid && cyc < 80) begin
      frame_tick = (cyc == extra_at);
      @(posedge clock); #1;
      cyc++;
    end
    frame_tick = 1'b0;
    lat = pos_valid ? cyc : -1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    n_total++; if (player_x !== 11'd16) $display("FAIL reset_x got %0d want 16", player_x); else n_pass++;
    n_total++; if (player_y !== 8'd16) $display("FAIL reset_y got %0d want 16", player_y); else n_pass++;
    n_total++; if (tile_x !== 7'd1 || tile_y !== 4'd1) $display("FAIL reset_tile got %0d,%0d want 1,1", tile_x, tile_y); else n_pass++;
    n_total++; if ({coll_enable, pos_valid, overrun} !== 3'b000) $display("FAIL reset_strobes got %b want 000", {coll_enable, pos_valid, overrun}); else n_pass++;
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_fall();
    int lat, pv0;
    pv0 = pv_cnt;
    for (int i = 0; i < 3; i++) begin
      run_frame(0, 0, 0, 0, 0, 0, 0, -1, lat);
      model_step(0, 0, 0, 0, 0, 0, 0);
      n_total++; if (lat != 4) $display("FAIL fall_latency got %0d want 4", lat); else n_pass++;
      n_total++; if (player_y !== 8'(20 + 4 * i)) $display("FAIL fall_y got %0d want %0d", player_y, 20 + 4 * i); else n_pass++;
      n_total++; if (player_x !== 11'd16) $display("FAIL fall_x got %0d want 16", player_x); else n_pass++;
    end
    @(posedge clock); #1;
    n_total++; if (pv_cnt - pv0 != 3) $display("FAIL fall_pos_valid got %0d want 3", pv_cnt - pv0); else n_pass++;
  endtask

  task automatic test_ground_jump();
    int lat;
    run_frame(0, 0, 0, 0, 0, 0, 1, -1, lat);
    model_step(0, 0, 0, 0, 0, 0, 1);
    n_total++; if (player_y !== 8'd28) $display("FAIL land_y got %0d want 28", player_y); else n_pass++;
    run_frame(0, 0, 1, 0, 0, 0, 1, -1, lat);
    model_step(0, 0, 1, 0, 0, 0, 1);
    n_total++; if (player_y !== 8'd28) $display("FAIL jump_start_y got %0d want 28", player_y); else n_pass++;
    for (int i = 0; i < 12; i++) begin
      run_frame(0, 0, 1, 0, 0, 0, 0, -1, lat);
      model_step(0, 0, 1, 0, 0, 0, 0);
      n_total++; if (player_y !== 8'(m_y)) $display("FAIL rise_y got %0d want %0d", player_y, m_y); else n_pass++;
    end
    n_total++; if (player_y !== 8'd0) $display("FAIL rise_top got %0d want 0", player_y); else n_pass++;
    run_frame(0, 0, 1, 0, 0, 0, 0, -1, lat);
    model_step(0, 0, 1, 0, 0, 0, 0);
    n_total++; if (player_y !== 8'd4) $display("FAIL jump_end_fall got %0d want 4", player_y); else n_pass++;
  endtask

  task automatic test_walk_right();
    int lat;
    run_frame(0, 1, 0, 0, 1, 0, 1, -1, lat);
    model_step(0, 1, 0, 0, 1, 0, 1);
    n_total++; if (player_x !== 11'd16) $display("FAIL right_blocked got %0d want 16", player_x); else n_pass++;
    for (int i = 0; i < 790; i++) begin
      run_frame(0, 1, 0, 0, 0, 0, 1, -1, lat);
      model_step(0, 1, 0, 0, 0, 0, 1);
      n_total++; if (player_x !== 11'(m_x)) $display("FAIL right_x got %0d want %0d", player_x, m_x); else n_pass++;
    end
    n_total++; if (player_x !== 11'd1584 || tile_x !== 7'd99) $display("FAIL right_limit got %0d tile %0d want 1584 tile 99", player_x, tile_x); else n_pass++;
  endtask

  task automatic test_walk_left();
    int lat;
    for (int i = 0; i < 795; i++) begin
      run_frame(1, 0, 0, 0, 0, 0, 1, -1, lat);
      model_step(1, 0, 0, 0, 0, 0, 1);
      n_total++; if (player_x !== 11'(m_x)) $display("FAIL left_x got %0d want %0d", player_x, m_x); else n_pass++;
    end
    n_total++; if (player_x !== 11'd0) $display("FAIL left_limit got %0d want 0", player_x); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      run_frame(0, 1, 0, 0, 0, 0, 1, -1, lat);
      model_step(0, 1, 0, 0, 0, 0, 1);
    end
    for (int i = 0; i < 3; i++) begin
      run_frame(1, 1, 0, 0, 0, 0, 1, -1, lat);
      model_step(1, 1, 0, 0, 0, 0, 1);
      n_total++; if (player_x !== 11'd6) $display("FAIL both_buttons_x got %0d want 6", player_x); else n_pass++;
    end
  endtask

  task automatic test_overrun();
    int lat, en0, ov0;
    en0 = en_cnt; ov0 = ovr_cnt;
    run_frame(0, 1, 0, 0, 0, 0, 1, 1, lat);
    model_step(0, 1, 0, 0, 0, 0, 1);
    @(posedge clock); #1;
    n_total++; if (ovr_cnt - ov0 != 1) $display("FAIL overrun_pulses got %0d want 1", ovr_cnt - ov0); else n_pass++;
    n_total++; if (en_cnt - en0 != 1) $display("FAIL overrun_enables got %0d want 1", en_cnt - en0); else n_pass++;
    n_total++; if (lat != 4) $display("FAIL overrun_latency got %0d want 4", lat); else n_pass++;
    n_total++; if (player_x !== 11'(m_x)) $display("FAIL overrun_x got %0d want %0d", player_x, m_x); else n_pass++;
  endtask

  task automatic test_done_hold();
    int lat;
    det_hold = 3;
    run_frame(0, 1, 0, 0, 0, 0, 1, -1, lat);
    model_step(0, 1, 0, 0, 0, 0, 1);
    det_hold = 0;
    n_total++; if (lat != 7) $display("FAIL done_hold_latency got %0d want 7", lat); else n_pass++;
    n_total++; if (player_x !== 11'(m_x)) $display("FAIL done_hold_x got %0d want %0d", player_x, m_x); else n_pass++;
  endtask

  task automatic test_random();
    int lat, en0, ov0;
    bit l, r, j, bl, br, bu, bd;
    en0 = en_cnt; ov0 = ovr_cnt;
    for (int i = 0; i < 200; i++) begin
      l = 1'($urandom); r = 1'($urandom); j = 1'($urandom);
      bl = 1'($urandom); br = 1'($urandom); bu = ($urandom_range(3) == 0); bd = 1'($urandom);
      det_hold = $urandom_range(3); det_busy = $urandom_range(4, 2);
      run_frame(l, r, j, bl, br, bu, bd, -1, lat);
      model_step(l, r, j, bl, br, bu, bd);
      n_total++; if (lat != 2 + det_hold + det_busy) $display("FAIL rand_latency got %0d want %0d", lat, 2 + det_hold + det_busy); else n_pass++;
      n_total++; if (player_x !== 11'(m_x) || tile_x !== 7'(m_x >> 4)) $display("FAIL rand_x got %0d want %0d", player_x, m_x); else n_pass++;
      n_total++; if (player_y !== 8'(m_y) || tile_y !== 4'(m_y >> 4)) $display("FAIL rand_y got %0d want %0d", player_y, m_y); else n_pass++;
    end
    det_hold = 0; det_busy = 2;
    @(posedge clock); #1;
    n_total++; if (en_cnt - en0 != 200) $display("FAIL rand_enables got %0d want 200", en_cnt - en0); else n_pass++;
    n_total++; if (ovr_cnt != ov0) $display("FAIL rand_overrun got %0d want 0", ovr_cnt - ov0); else n_pass++;
  endtask

  task automatic test_reset_mid_frame();
    int lat, cyc;
    det_busy = 20;
    @(posedge clock); #1;
    frame_tick = 1'b1;
    @(posedge clock); #1;
    frame_tick = 1'b0;
    repeat (4) @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock); #1;
    n_total++; if (player_x !== 11'd16 || player_y !== 8'd16) $display("FAIL midreset_pos got %0d,%0d want 16,16", player_x, player_y); else n_pass++;
    n_total++; if ({coll_enable, pos_valid, overrun} !== 3'b000) $display("FAIL midreset_strobes got %b want 000", {coll_enable, pos_valid, overrun}); else n_pass++;
    reset = 1'b0;
    model_reset();
    cyc = 0;
    while (!coll_done && cyc < 60) begin @(posedge clock); #1; cyc++; end
    n_total++; if (coll_done !== 1'b1) $display("FAIL midreset_detector_idle got %b want 1", coll_done); else n_pass++;
    det_busy = 2;
    run_frame(0, 0, 0, 0, 0, 0, 0, -1, lat);
    model_step(0, 0, 0, 0, 0, 0, 0);
    n_total++; if (lat != 4) $display("FAIL midreset_latency got %0d want 4", lat); else n_pass++;
    n_total++; if (player_y !== 8'd20 || player_x !== 11'd16) $display("FAIL midreset_frame got %0d,%0d want 16,20", player_x, player_y); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_fall();
    test_ground_jump();
    test_walk_right();
    test_walk_left();
    test_overrun();
    test_done_hold();
    test_random();
    test_reset_mid_frame();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
